ipsum_load_ctrl: RTL and testbench

// Sequences one input-psum tile from the GLB into the 32-row ipsum FIFO buffer, then drains it to the Reducer.

---
 rtl/ipsum_pkg.sv | 24 ++
 rtl/ipsum_load_ctrl.sv | 149 ++++++++++++++
 tb/tb_ipsum_load_ctrl.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ipsum_pkg.sv
// Shared definitions for the ipsum load controller.
// Contents: buffer geometry (rows, FIFO depth, words per row), the
// controller state type and a helper that clamps a requested row count.
package ipsum_pkg;

   localparam int unsigned ROW_NUM       = 32;
   localparam int unsigned IPSUM_DEPTH   = 4;
   localparam int unsigned WORDS_PER_ROW = IPSUM_DEPTH / 2;
   // One Reducer shift per 16-bit FIFO entry.
   localparam int unsigned DRAIN_SHIFTS  = IPSUM_DEPTH;

   typedef enum logic [1:0] {
      IPL_IDLE,
      IPL_LOAD,
      IPL_DRAIN,
      IPL_DONE
   } ipl_state_t;

   // Requests above the physical row count are treated as a full tile.
   function automatic logic [5:0] clamp_rows(input logic [5:0] rows);
      return (rows > 6'(ROW_NUM)) ? 6'(ROW_NUM) : rows;
   endfunction

endpackage

// File: rtl/ipsum_load_ctrl.sv
// ipsum_load_ctrl: loads one input-psum tile from the GLB into the 32-row
// ipsum FIFO buffer (two 32-bit words per active row), then drains it to
// the Reducer with exactly four shift cycles.
//
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   start               1-cycle tile request, accepted only when idle
//   row_en[5:0]         active rows (1..32, larger values clamp to 32)
//   base_addr           GLB word address of row 0 / word 0
//   valid_ip            GLB read data valid
//   glb_rreq            GLB read request (high during LOAD)
//   glb_raddr           GLB read address = base + words accepted
//   ready_ip            buffer/GLB ready (high during LOAD)
//   row_idx[4:0]        buffer row currently written
//   red_ready           Reducer can take one psum vector
//   ipsum_out_f         buffer shift enable toward the Reducer
//   busy                controller not idle
//   done                1-cycle completion pulse
//
// Build option IPSUM_LOAD_CTRL_PERF_EN adds stall_cnt[15:0] (LOAD cycles
// without valid_ip) and drain_stall_cnt[15:0] (DRAIN cycles without
// red_ready); both clear on an accepted start and saturate at 0xFFFF.
module ipsum_load_ctrl
   import ipsum_pkg::*;
#(
   parameter int unsigned ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [5:0]        row_en,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              valid_ip,
   output logic              glb_rreq,
   output logic [ADDR_W-1:0] glb_raddr,
   output logic              ready_ip,
   output logic [4:0]        row_idx,
   input  logic              red_ready,
   output logic              ipsum_out_f,
   output logic              busy,
`ifdef IPSUM_LOAD_CTRL_PERF_EN
   output logic [15:0]       stall_cnt,
   output logic [15:0]       drain_stall_cnt,
`endif
   output logic              done
);

   ipl_state_t        state_q, state_d;
   logic [5:0]        row_n_q, row_n_d;
   logic [ADDR_W-1:0] base_q, base_d;
   // One bit wider than needed for 64 words so the final increment is harmless.
   logic [6:0]        word_cnt_q, word_cnt_d;
   logic [1:0]        drain_cnt_q, drain_cnt_d;
   logic [6:0]        last_word;

   assign last_word = 7'(row_n_q * WORDS_PER_ROW) - 7'd1;

   always_comb begin
      state_d     = state_q;
      row_n_d     = row_n_q;
      base_d      = base_q;
      word_cnt_d  = word_cnt_q;
      drain_cnt_d = drain_cnt_q;
      glb_rreq    = 1'b0;
      ready_ip    = 1'b0;
      ipsum_out_f = 1'b0;
      done        = 1'b0;
      busy        = (state_q != IPL_IDLE);
      glb_raddr   = base_q + ADDR_W'(word_cnt_q);
      row_idx     = word_cnt_q[5:1];

      case (state_q)
         IPL_IDLE: begin
            if (start) begin
               row_n_d     = clamp_rows(row_en);
               base_d      = base_addr;
               word_cnt_d  = '0;
               drain_cnt_d = '0;
               state_d     = (row_en == 6'd0) ? IPL_DONE : IPL_LOAD;
            end
         end
         IPL_LOAD: begin
            glb_rreq = 1'b1;
            ready_ip = 1'b1;
            if (valid_ip) begin
               word_cnt_d = word_cnt_q + 7'd1;
               if (word_cnt_q == last_word) begin
                  state_d = IPL_DRAIN;
               end
            end
         end
         IPL_DRAIN: begin
            ipsum_out_f = red_ready;
            if (red_ready) begin
               drain_cnt_d = drain_cnt_q + 2'd1;
               if (drain_cnt_q == 2'(DRAIN_SHIFTS - 1)) begin
                  state_d = IPL_DONE;
               end
            end
         end
         IPL_DONE: begin
            done    = 1'b1;
            state_d = IPL_IDLE;
         end
         default: state_d = IPL_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IPL_IDLE;
         row_n_q     <= '0;
         base_q      <= '0;
         word_cnt_q  <= '0;
         drain_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         row_n_q     <= row_n_d;
         base_q      <= base_d;
         word_cnt_q  <= word_cnt_d;
         drain_cnt_q <= drain_cnt_d;
      end
   end

`ifdef IPSUM_LOAD_CTRL_PERF_EN
   logic [15:0] stall_cnt_q, drain_stall_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q       <= '0;
         drain_stall_cnt_q <= '0;
      end else if (state_q == IPL_IDLE && start) begin
         stall_cnt_q       <= '0;
         drain_stall_cnt_q <= '0;
      end else begin
         if (state_q == IPL_LOAD && !valid_ip && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
         if (state_q == IPL_DRAIN && !red_ready && drain_stall_cnt_q != 16'hFFFF) begin
            drain_stall_cnt_q <= drain_stall_cnt_q + 16'd1;
         end
      end
   end

   assign stall_cnt       = stall_cnt_q;
   assign drain_stall_cnt = drain_stall_cnt_q;
`endif

endmodule

// File: tb/tb_ipsum_load_ctrl.sv
// Directed self-checking bench for ipsum_load_ctrl. Inputs change 1 ns after
// the rising edge; outputs are sampled 4 ns after the rising edge. Cycle
// numbers count the cycle in which start is driven as cycle 1.
module tb_ipsum_load_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [5:0]  row_en;
   logic [15:0] base_addr;
   logic        valid_ip;
   logic        glb_rreq;
   logic [15:0] glb_raddr;
   logic        ready_ip;
   logic [4:0]  row_idx;
   logic        red_ready;
   logic        ipsum_out_f;
   logic        busy;
   logic        done;
`ifdef IPSUM_LOAD_CTRL_PERF_EN
   logic [15:0] stall_cnt;
   logic [15:0] drain_stall_cnt;
`endif

   int n_pass  = 0;
   int n_total = 0;

   // Observations from the most recent run_tile call.
   int          r_hs, r_ips, r_rdy, r_done;
   logic [15:0] r_last;
   logic [15:0] r_addr [0:3];
   logic [4:0]  r_row  [0:3];

   always #5 clk = ~clk;

   ipsum_load_ctrl #(.ADDR_W(16)) dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .row_en          (row_en),
      .base_addr       (base_addr),
      .valid_ip        (valid_ip),
      .glb_rreq        (glb_rreq),
      .glb_raddr       (glb_raddr),
      .ready_ip        (ready_ip),
      .row_idx         (row_idx),
      .red_ready       (red_ready),
      .ipsum_out_f     (ipsum_out_f),
      .busy            (busy),
`ifdef IPSUM_LOAD_CTRL_PERF_EN
      .stall_cnt       (stall_cnt),
      .drain_stall_cnt (drain_stall_cnt),
`endif
      .done            (done)
   );

   // Drives one tile and records what the DUT did; the test tasks check it.
   // vmode 0: valid always; 1: valid on odd cycles; 2: gaps in cycles 3 and 5.
   task automatic run_tile(input logic [5:0] re, input logic [15:0] base, input int vmode,
                           input int rr_lo, input int rr_len, input int xstart);
      r_hs = 0; r_ips = 0; r_rdy = 0; r_done = 0; r_last = '0;
      for (int k = 0; k < 4; k++) begin
         r_addr[k] = '0;
         r_row[k]  = '0;
      end
      for (int cyc = 1; cyc <= 300 && r_done == 0; cyc++) begin
         start     = (cyc == 1) || (cyc == xstart);
         row_en    = (cyc == 1) ? re : 6'd1;
         base_addr = (cyc == 1) ? base : 16'h5555;
         case (vmode)
            0:       valid_ip = 1'b1;
            1:       valid_ip = cyc[0];
            default: valid_ip = !(cyc == 3 || cyc == 5);
         endcase
         red_ready = !(cyc >= rr_lo && cyc < rr_lo + rr_len);
         #3;
         if (ready_ip && valid_ip) begin
            if (r_hs < 4) begin
               r_addr[r_hs] = glb_raddr;
               r_row[r_hs]  = row_idx;
            end
            r_last = glb_raddr;
            r_hs++;
         end
         if (ready_ip) r_rdy++;
         if (ipsum_out_f) r_ips++;
         if (done) r_done = cyc;
         @(posedge clk);
         #1;
      end
      start     = 1'b0;
      valid_ip  = 1'b0;
      red_ready = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; row_en = '0; base_addr = '0;
      valid_ip = 1'b1; red_ready = 1'b1;
      repeat (3) @(posedge clk);
      #4;
      n_total++;
      if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
      n_total++;
      if (ready_ip !== 1'b0 || glb_rreq !== 1'b0)
         $display("FAIL reset_ready: got ready=%b rreq=%b want 0/0", ready_ip, glb_rreq);
      else n_pass++;
      n_total++;
      if (glb_raddr !== 16'h0000 || row_idx !== 5'd0)
         $display("FAIL reset_addr: got raddr=%h row=%0d want 0000/0", glb_raddr, row_idx);
      else n_pass++;
      n_total++;
      if (ipsum_out_f !== 1'b0 || done !== 1'b0)
         $display("FAIL reset_out: got out_f=%b done=%b want 0/0", ipsum_out_f, done);
      else n_pass++;
`ifdef IPSUM_LOAD_CTRL_PERF_EN
      n_total++;
      if (stall_cnt !== 16'd0 || drain_stall_cnt !== 16'd0)
         $display("FAIL reset_perf: got %0d/%0d want 0/0", stall_cnt, drain_stall_cnt);
      else n_pass++;
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      valid_ip = 1'b0;
      #3;
      n_total++;
      if (busy !== 1'b0 || ready_ip !== 1'b0)
         $display("FAIL reset_release_idle: got busy=%b ready=%b want 0/0", busy, ready_ip);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_basic();
      run_tile(6'd2, 16'h0100, 0, 0, 0, 0);
      n_total++;
      if (r_hs !== 4) $display("FAIL t1_handshakes: got %0d want 4", r_hs); else n_pass++;
      n_total++;
      if (r_addr[0] !== 16'h0100 || r_addr[1] !== 16'h0101 ||
          r_addr[2] !== 16'h0102 || r_addr[3] !== 16'h0103)
         $display("FAIL t1_raddr: got %h %h %h %h want 0100 0101 0102 0103",
                  r_addr[0], r_addr[1], r_addr[2], r_addr[3]);
      else n_pass++;
      n_total++;
      if (r_row[0] !== 5'd0 || r_row[1] !== 5'd0 || r_row[2] !== 5'd1 || r_row[3] !== 5'd1)
         $display("FAIL t1_row_idx: got %0d %0d %0d %0d want 0 0 1 1",
                  r_row[0], r_row[1], r_row[2], r_row[3]);
      else n_pass++;
      n_total++;
      if (r_ips !== 4) $display("FAIL t1_shifts: got %0d want 4", r_ips); else n_pass++;
      n_total++;
      if (r_done !== 10) $display("FAIL t1_done_cycle: got %0d want 10", r_done); else n_pass++;
   endtask

   task automatic test_full_toggle();
      run_tile(6'd32, 16'h1000, 1, 0, 0, 0);
      n_total++;
      if (r_hs !== 64) $display("FAIL t2_handshakes: got %0d want 64", r_hs); else n_pass++;
      n_total++;
      if (r_last !== 16'h103F) $display("FAIL t2_last_raddr: got %h want 103f", r_last);
      else n_pass++;
      // Ready from cycle 2 through the 64th handshake in cycle 129, then low.
      n_total++;
      if (r_rdy !== 128) $display("FAIL t2_ready_cycles: got %0d want 128", r_rdy); else n_pass++;
      n_total++;
      if (r_done !== 134) $display("FAIL t2_done_cycle: got %0d want 134", r_done); else n_pass++;
`ifdef IPSUM_LOAD_CTRL_PERF_EN
      n_total++;
      if (stall_cnt !== 16'd64) $display("FAIL t2_stall_cnt: got %0d want 64", stall_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_row_bounds();
      run_tile(6'd0, 16'h0200, 0, 0, 0, 0);
      n_total++;
      if (r_rdy !== 0 || r_ips !== 0)
         $display("FAIL t3_empty_activity: got ready=%0d shifts=%0d want 0/0", r_rdy, r_ips);
      else n_pass++;
      n_total++;
      if (r_done !== 2) $display("FAIL t3_empty_done: got %0d want 2", r_done); else n_pass++;
      run_tile(6'd40, 16'h2000, 0, 0, 0, 0);
      n_total++;
      if (r_hs !== 64) $display("FAIL t3_clamp_handshakes: got %0d want 64", r_hs); else n_pass++;
      n_total++;
      if (r_last !== 16'h203F) $display("FAIL t3_clamp_last: got %h want 203f", r_last);
      else n_pass++;
      n_total++;
      if (r_done !== 70) $display("FAIL t3_clamp_done: got %0d want 70", r_done); else n_pass++;
   endtask

   task automatic test_drain_stall();
      // Drain starts in cycle 4; Reducer not ready in cycles 5..7.
      run_tile(6'd1, 16'h0020, 0, 5, 3, 0);
      n_total++;
      if (r_ips !== 4) $display("FAIL t4_shifts: got %0d want 4", r_ips); else n_pass++;
      n_total++;
      if (r_done !== 11) $display("FAIL t4_done_cycle: got %0d want 11", r_done); else n_pass++;
`ifdef IPSUM_LOAD_CTRL_PERF_EN
      n_total++;
      if (drain_stall_cnt !== 16'd3)
         $display("FAIL t4_drain_stall: got %0d want 3", drain_stall_cnt);
      else n_pass++;
`endif
   endtask

   task automatic test_busy_start_and_abort();
      // Second start in cycle 4 with row_en=1 must not disturb the 4-row tile.
      run_tile(6'd4, 16'h0400, 0, 0, 0, 4);
      n_total++;
      if (r_hs !== 8) $display("FAIL t5_ignored_start_hs: got %0d want 8", r_hs); else n_pass++;
      n_total++;
      if (r_done !== 14) $display("FAIL t5_ignored_start_done: got %0d want 14", r_done);
      else n_pass++;

      start = 1'b1; row_en = 6'd4; base_addr = 16'h0300; valid_ip = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      #1;
      n_total++;
      if (glb_raddr !== 16'h0302 || row_idx !== 5'd1)
         $display("FAIL t5_pre_abort: got raddr=%h row=%0d want 0302/1", glb_raddr, row_idx);
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if (busy !== 1'b0 || ready_ip !== 1'b0 || glb_rreq !== 1'b0)
         $display("FAIL t5_abort_ctrl: got busy=%b ready=%b rreq=%b want 0/0/0",
                  busy, ready_ip, glb_rreq);
      else n_pass++;
      n_total++;
      if (glb_raddr !== 16'h0000 || row_idx !== 5'd0)
         $display("FAIL t5_abort_addr: got raddr=%h row=%0d want 0000/0", glb_raddr, row_idx);
      else n_pass++;
      @(posedge clk);
      #1;
      reset = 1'b0;
      valid_ip = 1'b0;
      @(posedge clk);
      #1;
      run_tile(6'd2, 16'h0100, 0, 0, 0, 0);
      n_total++;
      if (r_hs !== 4 || r_addr[0] !== 16'h0100)
         $display("FAIL t5_after_abort: got hs=%0d raddr0=%h want 4/0100", r_hs, r_addr[0]);
      else n_pass++;
      n_total++;
      if (r_done !== 10) $display("FAIL t5_after_abort_done: got %0d want 10", r_done);
      else n_pass++;
   endtask

   task automatic test_addr_wrap();
      // valid_ip gaps in cycles 3 and 5: handshakes in cycles 2,4,6,7.
      run_tile(6'd2, 16'hFFFE, 2, 0, 0, 0);
      n_total++;
      if (r_addr[0] !== 16'hFFFE || r_addr[1] !== 16'hFFFF ||
          r_addr[2] !== 16'h0000 || r_addr[3] !== 16'h0001)
         $display("FAIL t6_wrap_raddr: got %h %h %h %h want fffe ffff 0000 0001",
                  r_addr[0], r_addr[1], r_addr[2], r_addr[3]);
      else n_pass++;
      n_total++;
      if (r_done !== 12) $display("FAIL t6_done_cycle: got %0d want 12", r_done); else n_pass++;
`ifdef IPSUM_LOAD_CTRL_PERF_EN
      n_total++;
      if (stall_cnt !== 16'd2 || drain_stall_cnt !== 16'd0)
         $display("FAIL t6_perf: got stall=%0d drain=%0d want 2/0", stall_cnt, drain_stall_cnt);
      else n_pass++;
`endif
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full_toggle();
      test_row_bounds();
      test_drain_stall();
      test_busy_start_and_abort();
      test_addr_wrap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
